cv_ctrl_ports: RTL and testbench
================================

// Module: cv_ctrl_ports
// PURPOSE
//  Parametrised ColecoVision controller-port front end: maps MiSTer joystick words onto the
//  DE-9 pin levels (p1-p4, p6, p7, p9) for NUM_PORTS ports, driven by console strobes p5/p8.
//  Adds per-port debounce and Super Action spinner emulation (quadrature on p7/p9).
//  Sits between hps_io joystick outputs and cv_console ctrl_p*_i pins.
// PARAMETERS
//  NUM_PORTS   2   number of controller ports (1..4)
//  DEB_W       4   debounce counter width; input must be stable 2**DEB_W-1 ce ticks
//  SPIN_DIV    64  ce ticks between spinner quadrature steps (>=2)
// PORTS
//  clk_i         in   1             system clock
//  reset_n_i     in   1             synchronous, active-low reset
//  clk_en_i      in   1             tick enable (10.7 MHz ce); all counters advance only on it
//  joy_i         in   32*NUM_PORTS  per port: [3:0] U,D,L,R=[3],[2],[1],[0]; [4] fire1; [5] fire2;
//                                   [6] *; [7] #; [17:8] keys 0-9; [18] purple; [19] blue; rest ignored
//  spin_en_i     in   NUM_PORTS     1 = spinner mode on port (p7/p9 driven by quadrature)
//  spin_stb_i    in   NUM_PORTS     one-clk strobe: accumulate spin_delta_i for that port
//  spin_delta_i  in   8*NUM_PORTS   signed two's-complement movement per strobe
//  ctrl_p5_i     in   NUM_PORTS     keypad select, active low
//  ctrl_p8_i     in   NUM_PORTS     joystick select, active low
//  ctrl_p1_o..ctrl_p4_o out NUM_PORTS  pin 1-4 levels (registered)
//  ctrl_p6_o     out  NUM_PORTS     fire pin level (registered)
//  ctrl_p7_o, ctrl_p9_o out NUM_PORTS  spinner quadrature A/B (registered)
// BEHAVIOUR
//  Reset (reset_n_i=0 at clk edge): all outputs 1; debounced state 0; deb counters 0;
//   spin accumulators 0; quadrature phase 2'b11; spin dividers 0. Dominates all other events.
//  Debounce, per port on 20-bit vector joy_i[19:0]: raw != last_raw -> counter 0, last_raw<=raw;
//   else on clk_en_i, counter++ saturating; at all-ones, deb<=last_raw. Change lasting
//   < 2**DEB_W-1 ticks never reaches deb.
//  Keypad code (p5 low), priority highest first on deb bits: 0=0011 1=1110 2=1101 3=0110
//   4=0001 5=1001 6=0111 7=1100 8=1000 9=1011 *=1010 #=0101 purple=0100 blue=0010 none=1111;
//   code order {p1,p2,p3,p4}; p6 term = ~fire2.
//  Joystick (p8 low): {p1,p2,p3,p4} = ~{U,D,L,R}; p6 term = ~fire1.
//  Both low: bitwise AND of both terms. Both high: pins 1111, p6=1.
//  Pin outputs registered: 1 clk latency from p5/p8/deb change (independent of clk_en_i).
//  Spinner, per port: acc signed 10 bit. On spin_stb_i: acc <= sat(acc + sext(delta)), sat to
//   [-511,+511]. Divider counts clk_en_i ticks 0..SPIN_DIV-1; on terminal tick with acc!=0:
//   phase steps one Gray position (fwd if acc>0: 11->10->00->01->11; reverse if acc<0) and
//   acc moves 1 toward 0. Strobe and step same clk: acc <= sat(acc + delta - sign(acc)).
//  p7=phase[1], p9=phase[0] when spin_en_i; else both 1 and phase/acc held. Clearing
//   spin_en_i zeroes acc. Ports fully independent; no cross-port state.
// TESTING
//  Reset with keys held, p5=p8=0 -> all outputs 1 during reset; after release pins stay 1111
//   until 15 ce ticks of stable input (DEB_W=4), then reflect keys.
//  Port0 key 5 and key 9 held, p5=0 p8=1 -> {p1..p4}=1001 (5 wins); release 5 -> 1011.
//  Port1 U+fire1, p8=0 p5=1 -> pins 0111, p6=0; toggle p8 high -> 1111, p6=1 one clk later.
//  Glitch: joy bit pulses 10 ce ticks -> outputs unchanged; 20-tick pulse -> propagates.
//  Spinner: spin_en=1, delta=+3 strobe -> p7/p9 = 10,00,01 at ticks 64,128,192, then holds;
//   delta=-2 -> 00,10 reverse.
//  Saturation: 3 strobes of +127 then 2 of +127 -> acc clamps at 511 minus steps taken.

Source files
------------

// File: rtl/cv_ctrl_ports_if.sv
// Controller-port bus: joystick words, spinner controls, console strobes and DE-9 pin levels.
// The console/host side drives through master; the port front end uses slave.
interface cv_ctrl_ports_if #(
    parameter int unsigned NUM_PORTS = 2
);
    logic [32*NUM_PORTS-1:0] joy_i;
    logic [NUM_PORTS-1:0]    spin_en_i;
    logic [NUM_PORTS-1:0]    spin_stb_i;
    logic [8*NUM_PORTS-1:0]  spin_delta_i;
    logic [NUM_PORTS-1:0]    ctrl_p5_i;
    logic [NUM_PORTS-1:0]    ctrl_p8_i;
    logic [NUM_PORTS-1:0]    ctrl_p1_o;
    logic [NUM_PORTS-1:0]    ctrl_p2_o;
    logic [NUM_PORTS-1:0]    ctrl_p3_o;
    logic [NUM_PORTS-1:0]    ctrl_p4_o;
    logic [NUM_PORTS-1:0]    ctrl_p6_o;
    logic [NUM_PORTS-1:0]    ctrl_p7_o;
    logic [NUM_PORTS-1:0]    ctrl_p9_o;

    modport master (
        output joy_i, spin_en_i, spin_stb_i, spin_delta_i, ctrl_p5_i, ctrl_p8_i,
        input  ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
    );

    modport slave (
        input  joy_i, spin_en_i, spin_stb_i, spin_delta_i, ctrl_p5_i, ctrl_p8_i,
        output ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
    );
endinterface

// File: rtl/cv_ctrl_ports.sv
// ColecoVision controller-port front end: debounced joystick/keypad pin mapping per port
// plus Super Action spinner quadrature emulation on p7/p9.
module cv_ctrl_ports #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEB_W     = 4,
    parameter int unsigned SPIN_DIV  = 64
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           clk_en_i,
    cv_ctrl_ports_if.slave bus
);
    localparam int unsigned JOY_W = 20;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned DIV_W = (SPIN_DIV > 2) ? $clog2(SPIN_DIV) : 1;
    localparam logic [DEB_W-1:0]        DEB_MAX  = '1;
    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SPIN_DIV - 1);
    localparam logic signed [SUM_W-1:0] ACC_HI   = 12'sd511;
    localparam logic signed [SUM_W-1:0] ACC_LO   = -12'sd511;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [JOY_W-1:0]        w_raw;
        logic                    w_unused_hi;
        logic [JOY_W-1:0]        r_last;
        logic [JOY_W-1:0]        r_deb;
        logic [DEB_W-1:0]        r_cnt;
        logic [3:0]              w_key;
        logic [3:0]              w_pins;
        logic                    w_fire;
        logic [3:0]              r_pins;
        logic                    r_p6;
        logic signed [ACC_W-1:0] r_acc;
        logic [1:0]              r_phase;
        logic [DIV_W-1:0]        r_div;
        logic                    r_p7;
        logic                    r_p9;
        logic signed [7:0]       w_delta;
        logic                    w_term;
        logic                    w_step;
        logic signed [SUM_W-1:0] w_inc;
        logic signed [SUM_W-1:0] w_adj;
        logic signed [SUM_W-1:0] w_sum;
        logic signed [ACC_W-1:0] w_acc_nxt;

        assign w_raw       = bus.joy_i[32*p +: JOY_W];
        assign w_unused_hi = ^bus.joy_i[32*p+JOY_W +: 32-JOY_W];

        // Debounce: any raw change restarts the stability count
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                r_last <= '0;
                r_deb  <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_raw != r_last) begin
                    r_last <= w_raw;
                    r_cnt  <= '0;
                end else if (clk_en_i && (r_cnt != DEB_MAX)) begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
                if (r_cnt == DEB_MAX) r_deb <= r_last;
            end
        end

        // Keypad priority encoder and select-line combining
        always_comb begin
            w_key = 4'b1111;
            if      (r_deb[8])  w_key = 4'b0011;
            else if (r_deb[9])  w_key = 4'b1110;
            else if (r_deb[10]) w_key = 4'b1101;
            else if (r_deb[11]) w_key = 4'b0110;
            else if (r_deb[12]) w_key = 4'b0001;
            else if (r_deb[13]) w_key = 4'b1001;
            else if (r_deb[14]) w_key = 4'b0111;
            else if (r_deb[15]) w_key = 4'b1100;
            else if (r_deb[16]) w_key = 4'b1000;
            else if (r_deb[17]) w_key = 4'b1011;
            else if (r_deb[6])  w_key = 4'b1010;
            else if (r_deb[7])  w_key = 4'b0101;
            else if (r_deb[18]) w_key = 4'b0100;
            else if (r_deb[19]) w_key = 4'b0010;
            w_pins = (bus.ctrl_p5_i[p] ? 4'b1111 : w_key)
                   & (bus.ctrl_p8_i[p] ? 4'b1111 : ~r_deb[3:0]);
            w_fire = (bus.ctrl_p5_i[p] ? 1'b1 : ~r_deb[5])
                   & (bus.ctrl_p8_i[p] ? 1'b1 : ~r_deb[4]);
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                r_pins <= 4'b1111;
                r_p6   <= 1'b1;
            end else begin
                r_pins <= w_pins;
                r_p6   <= w_fire;
            end
        end

        assign w_delta = bus.spin_delta_i[8*p +: 8];
        assign w_term  = clk_en_i && (r_div == DIV_LAST);
        assign w_step  = w_term && (r_acc != '0);

        // Accumulate strobed movement, retire one unit per step, clamp symmetric
        always_comb begin
            w_inc = '0;
            w_adj = '0;
            if (bus.spin_stb_i[p]) w_inc = {{(SUM_W-8){w_delta[7]}}, w_delta};
            if (w_step) w_adj = r_acc[ACC_W-1] ? {SUM_W{1'b1}} : SUM_W'(1);
            w_sum = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc} + w_inc - w_adj;
            w_acc_nxt = w_sum[ACC_W-1:0];
            if (w_sum > ACC_HI)      w_acc_nxt = ACC_HI[ACC_W-1:0];
            else if (w_sum < ACC_LO) w_acc_nxt = ACC_LO[ACC_W-1:0];
        end

        // Gray phase: forward 11->10->00->01, reverse the other way
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                r_acc   <= '0;
                r_phase <= 2'b11;
                r_div   <= '0;
                r_p7    <= 1'b1;
                r_p9    <= 1'b1;
            end else begin
                r_p7 <= bus.spin_en_i[p] ? r_phase[1] : 1'b1;
                r_p9 <= bus.spin_en_i[p] ? r_phase[0] : 1'b1;
                if (!bus.spin_en_i[p]) begin
                    r_acc <= '0;
                    r_div <= '0;
                end else begin
                    r_acc <= w_acc_nxt;
                    if (clk_en_i) r_div <= w_term ? '0 : r_div + DIV_W'(1);
                    if (w_step) begin
                        r_phase <= r_acc[ACC_W-1] ? {~r_phase[0], r_phase[1]}
                                                  : {r_phase[0], ~r_phase[1]};
                    end
                end
            end
        end

        assign bus.ctrl_p1_o[p] = r_pins[3];
        assign bus.ctrl_p2_o[p] = r_pins[2];
        assign bus.ctrl_p3_o[p] = r_pins[1];
        assign bus.ctrl_p4_o[p] = r_pins[0];
        assign bus.ctrl_p6_o[p] = r_p6;
        assign bus.ctrl_p7_o[p] = r_p7;
        assign bus.ctrl_p9_o[p] = r_p9;
    end
endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Self-checking bench for cv_ctrl_ports: pin mapping, debounce and spinner quadrature
// compared against a behavioural model of the port rules.
module tb_cv_ctrl_ports;
    localparam int unsigned NP       = 2;
    localparam int unsigned DEB_W    = 4;
    localparam int unsigned SPIN_DIV = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [31:0] joy0, joy1;
    logic [1:0]  p5, p8, sen, sstb;
    logic [7:0]  d0, d1;
    int          checks = 0;
    int          errors = 0;
    int          pos0;
    logic [1:0]  gray_tab [4];

    always #5 clk = ~clk;

    cv_ctrl_ports_if #(.NUM_PORTS(NP)) bus ();

    assign bus.joy_i        = {joy1, joy0};
    assign bus.spin_en_i    = sen;
    assign bus.spin_stb_i   = sstb;
    assign bus.spin_delta_i = {d1, d0};
    assign bus.ctrl_p5_i    = p5;
    assign bus.ctrl_p8_i    = p8;

    cv_ctrl_ports #(.NUM_PORTS(NP), .DEB_W(DEB_W), .SPIN_DIV(SPIN_DIV)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    function automatic logic [4:0] pins(input int p);
        return {bus.ctrl_p1_o[p], bus.ctrl_p2_o[p], bus.ctrl_p3_o[p], bus.ctrl_p4_o[p],
                bus.ctrl_p6_o[p]};
    endfunction

    function automatic logic [1:0] quad(input int p);
        return {bus.ctrl_p7_o[p], bus.ctrl_p9_o[p]};
    endfunction

    // Reference: {p1,p2,p3,p4,p6} for a settled joystick word and the two select lines
    function automatic logic [4:0] exp_pins(input logic [19:0] j, input logic sk_n, input logic sj_n);
        int unsigned prio [14];
        logic [3:0]  code [14];
        logic [3:0]  key_t, joy_t;
        logic        kf, jf;
        bit          found;
        prio  = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 6, 7, 18, 19};
        code  = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001, 4'b0111,
                  4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010};
        key_t = 4'b1111;
        found = 0;
        for (int i = 0; i < 14; i++) begin
            if (!found && j[prio[i]]) begin
                key_t = code[i];
                found = 1;
            end
        end
        joy_t = ~j[3:0];
        kf    = ~j[5];
        jf    = ~j[4];
        if (sk_n) begin key_t = 4'b1111; kf = 1'b1; end
        if (sj_n) begin joy_t = 4'b1111; jf = 1'b1; end
        return {key_t & joy_t, kf & jf};
    endfunction

    task automatic clk1(input logic ce);
        clk_en = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) clk1(1'b1);
    endtask

    task automatic run_ticks(input int n);
        int   t;
        logic ce;
        t = 0;
        while (t < n) begin
            ce = 1'($urandom_range(0, 1));
            clk1(ce);
            if (ce) t++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        joy0 = (32'd1 << 13) | (32'd1 << 4);
        joy1 = (32'd1 << 3) | (32'd1 << 4);
        p5 = 2'b00; p8 = 2'b00; sen = 2'b00; sstb = 2'b00; d0 = '0; d1 = '0;
        clk_en = 1'b1;
        run(3);
        checks++;
        if ({pins(1), quad(1), pins(0), quad(0)} !== 14'h3FFF) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all ones", {pins(1), quad(1), pins(0), quad(0)});
        end
        reset_n = 1'b1;
        run(10);
        checks++;
        if ({pins(1), pins(0)} !== 10'h3FF) begin
            errors++;
            $display("FAIL reset_pre_debounce: got %b want 1111111111", {pins(1), pins(0)});
        end
        run(10);
        checks++;
        if ({pins(1), pins(0)} !== {exp_pins(joy1[19:0], 1'b0, 1'b0), exp_pins(joy0[19:0], 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL reset_post_debounce: got %b want %b", {pins(1), pins(0)},
                     {exp_pins(joy1[19:0], 1'b0, 1'b0), exp_pins(joy0[19:0], 1'b0, 1'b0)});
        end
    endtask

    task automatic test_keypad_priority;
        p5[0] = 1'b0; p8[0] = 1'b1;
        joy0 = (32'd1 << 13) | (32'd1 << 17);
        run(20);
        checks++;
        if (pins(0) !== 5'b10011) begin
            errors++;
            $display("FAIL keypad_5_over_9: got %b want 10011", pins(0));
        end
        joy0 = 32'd1 << 17;
        run(20);
        checks++;
        if (pins(0) !== 5'b10111) begin
            errors++;
            $display("FAIL keypad_9: got %b want 10111", pins(0));
        end
    endtask

    task automatic test_joystick;
        joy1 = (32'd1 << 3) | (32'd1 << 4);
        p5[1] = 1'b1; p8[1] = 1'b0;
        run(20);
        checks++;
        if (pins(1) !== 5'b01110) begin
            errors++;
            $display("FAIL joystick_up_fire: got %b want 01110", pins(1));
        end
        p8[1] = 1'b1;
        #1;
        checks++;
        if (pins(1) !== 5'b01110) begin
            errors++;
            $display("FAIL joystick_registered: got %b want 01110", pins(1));
        end
        clk1(1'b0);
        checks++;
        if (pins(1) !== 5'b11111) begin
            errors++;
            $display("FAIL joystick_deselect: got %b want 11111", pins(1));
        end
    endtask

    task automatic test_glitch;
        logic [4:0] base;
        int         dev;
        int         t;
        logic       ce;
        base = exp_pins(joy0[19:0], p5[0], p8[0]);
        dev  = 0;
        t    = 0;
        joy0 = (32'd1 << 17) | (32'd1 << 8);
        while (t < 10) begin
            ce = 1'($urandom_range(0, 1));
            clk1(ce);
            if (ce) t++;
            if (pins(0) !== base) dev++;
        end
        joy0 = 32'd1 << 17;
        repeat (40) begin
            clk1(1'b1);
            if (pins(0) !== base) dev++;
        end
        checks++;
        if (dev !== 0) begin
            errors++;
            $display("FAIL glitch_short: %0d deviating cycles, want 0", dev);
        end
        joy0 = (32'd1 << 17) | (32'd1 << 8);
        run(19);
        checks++;
        if (pins(0) !== 5'b00111) begin
            errors++;
            $display("FAIL glitch_long: got %b want 00111", pins(0));
        end
        run(1);
        joy0 = 32'd1 << 17;
        run(20);
        checks++;
        if (pins(0) !== base) begin
            errors++;
            $display("FAIL glitch_restore: got %b want %b", pins(0), base);
        end
    endtask

    task automatic test_random_keys;
        logic [9:0] exp;
        for (int it = 0; it < 12; it++) begin
            joy0 = $urandom;
            joy1 = $urandom;
            p5   = 2'($urandom_range(0, 3));
            p8   = 2'($urandom_range(0, 3));
            run_ticks(17);
            clk1(1'b0);
            clk1(1'b0);
            exp = {exp_pins(joy1[19:0], p5[1], p8[1]), exp_pins(joy0[19:0], p5[0], p8[0])};
            checks++;
            if ({pins(1), pins(0)} !== exp) begin
                errors++;
                $display("FAIL random_keys[%0d]: joy0=%h joy1=%h got %b want %b",
                         it, joy0, joy1, {pins(1), pins(0)}, exp);
            end
            p5 = 2'($urandom_range(0, 3));
            p8 = 2'($urandom_range(0, 3));
            clk1(1'b0);
            exp = {exp_pins(joy1[19:0], p5[1], p8[1]), exp_pins(joy0[19:0], p5[0], p8[0])};
            checks++;
            if ({pins(1), pins(0)} !== exp) begin
                errors++;
                $display("FAIL random_select[%0d]: p5=%b p8=%b got %b want %b",
                         it, p5, p8, {pins(1), pins(0)}, exp);
            end
        end
    endtask

    task automatic test_spinner_directed;
        int         n;
        logic [1:0] e;
        bit         chk;
        logic [1:0] prev, cur;
        logic [1:0] q [$];
        logic [3:0] seq;
        checks++;
        if (quad(0) !== 2'b11) begin
            errors++;
            $display("FAIL spin_disabled_idle: got %b want 11", quad(0));
        end
        sen[0] = 1'b1; sstb[0] = 1'b1; d0 = 8'd3;
        clk1(1'b1);
        sstb[0] = 1'b0;
        n = 1;
        while (n < 300) begin
            clk1(1'b1);
            n++;
            chk = 1'b1;
            e   = 2'b11;
            case (n)
                64:      e = 2'b11;
                65:      e = 2'b10;
                128:     e = 2'b10;
                129:     e = 2'b00;
                193:     e = 2'b01;
                300:     e = 2'b01;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                checks++;
                if (quad(0) !== e) begin
                    errors++;
                    $display("FAIL spin_fwd@%0d: got %b want %b", n, quad(0), e);
                end
            end
        end
        d0 = 8'hFE; sstb[0] = 1'b1;
        clk1(1'b1);
        sstb[0] = 1'b0;
        prev = quad(0);
        repeat (3 * SPIN_DIV + 10) begin
            clk1(1'b1);
            cur = quad(0);
            if (cur !== prev) q.push_back(cur);
            prev = cur;
        end
        seq = 4'b1111;
        if (q.size() >= 2) seq = {q[0], q[1]};
        checks++;
        if (q.size() != 2 || seq !== 4'b0010) begin
            errors++;
            $display("FAIL spin_reverse: %0d steps seq %b want 2 steps 0010", q.size(), seq);
        end
        pos0 = 1;
        sen[0] = 1'b0;
        clk1(1'b1);
        checks++;
        if (quad(0) !== 2'b11) begin
            errors++;
            $display("FAIL spin_disable_out: got %b want 11", quad(0));
        end
    endtask

    task automatic test_spinner_random;
        int         da, db, total, mag, steps, t;
        logic       ce;
        logic [1:0] prev, cur;
        for (int it = 0; it < 6; it++) begin
            sen[0] = 1'b0;
            clk1(1'b1);
            da = int'($urandom_range(0, 40)) - 20;
            db = int'($urandom_range(0, 16)) - 8;
            sen[0] = 1'b1; sstb[0] = 1'b1; d0 = 8'(da);
            clk1(1'b1);
            prev = quad(0);
            sstb[0] = 1'b0;
            clk1(1'b1);
            clk1(1'b1);
            sstb[0] = 1'b1; d0 = 8'(db);
            clk1(1'b1);
            sstb[0] = 1'b0;
            total = da + db;
            mag   = (total < 0) ? -total : total;
            steps = 0;
            t     = 0;
            while (t < (mag + 1) * int'(SPIN_DIV) + 2) begin
                ce = 1'($urandom_range(0, 1));
                clk1(ce);
                if (ce) t++;
                cur = quad(0);
                if (cur !== prev) steps++;
                prev = cur;
            end
            clk1(1'b0);
            if (quad(0) !== prev) steps++;
            pos0 = (((pos0 + total) % 4) + 4) % 4;
            checks++;
            if (steps != mag || quad(0) !== gray_tab[pos0]) begin
                errors++;
                $display("FAIL spin_random[%0d]: delta %0d steps %0d phase %b want steps %0d phase %b",
                         it, total, steps, quad(0), mag, gray_tab[pos0]);
            end
        end
    endtask

    task automatic test_spinner_sat;
        int         steps;
        logic [1:0] prev, cur;
        sen[0] = 1'b0;
        clk1(1'b1);
        sen[0] = 1'b1; sstb[0] = 1'b1; d0 = 8'd127;
        repeat (5) clk1(1'b1);
        sstb[0] = 1'b0;
        prev  = quad(0);
        steps = 0;
        repeat (512 * SPIN_DIV + 100) begin
            clk1(1'b1);
            cur = quad(0);
            if (cur !== prev) steps++;
            prev = cur;
        end
        pos0 = (pos0 + 511) % 4;
        checks++;
        if (steps != 511 || quad(0) !== gray_tab[pos0]) begin
            errors++;
            $display("FAIL spin_saturate: steps %0d phase %b want 511 phase %b",
                     steps, quad(0), gray_tab[pos0]);
        end
    endtask

    task automatic test_spin_disable_clears;
        int         steps;
        logic [1:0] prev, cur;
        sen[0] = 1'b0;
        clk1(1'b1);
        sen[0] = 1'b1; sstb[0] = 1'b1; d0 = 8'd100;
        clk1(1'b1);
        sstb[0] = 1'b0;
        prev  = quad(0);
        steps = 0;
        repeat (10 * SPIN_DIV + 5) begin
            clk1(1'b1);
            cur = quad(0);
            if (cur !== prev) steps++;
            prev = cur;
        end
        pos0 = (pos0 + 10) % 4;
        checks++;
        if (steps != 10 || quad(0) !== gray_tab[pos0]) begin
            errors++;
            $display("FAIL spin_partial: steps %0d phase %b want 10 phase %b",
                     steps, quad(0), gray_tab[pos0]);
        end
        sen[0] = 1'b0;
        clk1(1'b1);
        sen[0] = 1'b1;
        clk1(1'b1);
        prev  = quad(0);
        steps = 0;
        repeat (5 * SPIN_DIV) begin
            clk1(1'b1);
            cur = quad(0);
            if (cur !== prev) steps++;
            prev = cur;
        end
        checks++;
        if (steps != 0 || quad(0) !== gray_tab[pos0]) begin
            errors++;
            $display("FAIL spin_disable_clears: steps %0d phase %b want 0 phase %b",
                     steps, quad(0), gray_tab[pos0]);
        end
        checks++;
        if (quad(1) !== 2'b11) begin
            errors++;
            $display("FAIL spin_port1_idle: got %b want 11", quad(1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gray_tab = '{2'b11, 2'b10, 2'b00, 2'b01};
        pos0     = 0;
        test_reset;
        test_keypad_priority;
        test_joystick;
        test_glitch;
        test_random_keys;
        test_spinner_directed;
        test_spinner_random;
        test_spinner_sat;
        test_spin_disable_clears;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
